// File: rtl/link_pkg.sv
// link_pkg: constants shared by both ends of the 16-bit serial link.
//   WORD_W        word width carried on the link
//   SYNC_PATTERN  alignment word, identical to the transmitter's constant
//   align_state_t one-hot aligner states (HUNT / VERIFY / LOCKED)
package link_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] SYNC_PATTERN = 16'h817E;

  typedef enum logic [2:0] {
    HUNT   = 3'b001,
    VERIFY = 3'b010,
    LOCKED = 3'b100
  } align_state_t;

endpackage

// File: rtl/des_align_sync_detect.sv
// sync_detect: compares the candidate word (the shift register value after
// this cycle's bit) against the alignment pattern and flags whether the
// phase counter sits on a word boundary.
// Ports:
//   shift_next   in  16  shift register contents including the current bit
//   bitcnt       in  4   bit phase counter
//   is_sync      out 1   candidate word equals PATTERN
//   at_boundary  out 1   this cycle closes a word at the held phase
module sync_detect
  import link_pkg::*;
#(
  parameter logic [WORD_W-1:0] PATTERN = link_pkg::SYNC_PATTERN
) (
  input  logic [WORD_W-1:0] shift_next,
  input  logic [3:0]        bitcnt,
  output logic              is_sync,
  output logic              at_boundary
);

  // Pure combinational compare; the phase counter's last count marks the
  // cycle whose bit completes a word.
  always_comb begin
    is_sync     = (shift_next == PATTERN);
    at_boundary = (bitcnt == 4'd15);
  end

endmodule

// File: rtl/des_align.sv
// des_align: receive-side deserializer and word aligner. Shifts in one bit
// per clk (MSB first), hunts for the sync pattern at any phase, verifies it
// repeats at a fixed phase, then delivers aligned words with a valid strobe.
// Ports:
//   clk           in  1   bit clock, one serial bit per rising edge
//   rst_n         in  1   asynchronous active-low reset
//   datain        in  1   synchronized serial bit
//   word          out 16  aligned word, first received bit in [15]
//   word_valid    out 1   one-cycle strobe, word valid
//   word_is_sync  out 1   word equals SYNC_PATTERN (qualifies word_valid)
//   locked        out 1   aligner is in LOCKED
//   lock_lost     out 1   one-cycle pulse on LOCKED -> HUNT
//   err_cnt       out 8   saturating lock-loss counter
// Build option: define DES_ALIGN_ERRCNT_EN to enable err_cnt; otherwise it
// is tied to zero and the counter is not built.
module des_align
  import link_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_PATTERN = link_pkg::SYNC_PATTERN,
  parameter int unsigned       SYNC_LOCK    = 4,
  parameter int unsigned       SYNC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              datain,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_is_sync,
  output logic              locked,
  output logic              lock_lost,
  output logic [7:0]        err_cnt
);

  localparam logic [3:0] LOCK_N    = 4'(SYNC_LOCK);
  localparam logic [7:0] TIMEOUT_N = 8'(SYNC_TIMEOUT);

  align_state_t      state, state_next;
  logic [WORD_W-1:0] sr, sr_next;
  logic [3:0]        bitcnt, bitcnt_next;
  logic [3:0]        synccnt, synccnt_next;
  logic [7:0]        misscnt, misscnt_next;
  logic              is_sync, at_boundary;
  logic              miss_limit;
  logic              emit, lost;

  // The candidate word always includes the bit arriving this cycle.
  assign sr_next = {sr[WORD_W-2:0], datain};

  sync_detect #(
    .PATTERN(SYNC_PATTERN)
  ) u_sync_detect (
    .shift_next (sr_next),
    .bitcnt     (bitcnt),
    .is_sync    (is_sync),
    .at_boundary(at_boundary)
  );

  // The non-sync word currently being judged would exhaust the miss budget.
  assign miss_limit = ((misscnt + 8'd1) == TIMEOUT_N);

  // State register plus the shift register and counters it steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      sr      <= '0;
      bitcnt  <= '0;
      synccnt <= '0;
      misscnt <= '0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      bitcnt  <= bitcnt_next;
      synccnt <= synccnt_next;
      misscnt <= misscnt_next;
    end
  end

  // Next-state logic. A HUNT match forces bitcnt to 0 so that the match
  // cycle acts as a boundary and the next one falls 16 bits later. Off-phase
  // sync words in VERIFY/LOCKED are ignored because only at_boundary cycles
  // are evaluated there.
  always_comb begin
    state_next   = state;
    bitcnt_next  = bitcnt + 4'd1;
    synccnt_next = synccnt;
    misscnt_next = misscnt;
    unique case (state)
      HUNT: begin
        if (is_sync) begin
          bitcnt_next  = 4'd0;
          synccnt_next = 4'd1;
          misscnt_next = 8'd0;
          state_next   = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (at_boundary) begin
          if (is_sync) begin
            synccnt_next = synccnt + 4'd1;
            if ((synccnt + 4'd1) == LOCK_N) begin
              state_next   = LOCKED;
              misscnt_next = 8'd0;
            end
          end else begin
            state_next   = HUNT;
            synccnt_next = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (at_boundary) begin
          if (is_sync) begin
            misscnt_next = 8'd0;
          end else if (miss_limit) begin
            state_next   = HUNT;
            misscnt_next = 8'd0;
            synccnt_next = 4'd0;
          end else begin
            misscnt_next = misscnt + 8'd1;
          end
        end
      end
      default: begin
        state_next   = HUNT;
        synccnt_next = 4'd0;
        misscnt_next = 8'd0;
      end
    endcase
  end

  // Output decode: a locked boundary emits its word unless that word is the
  // one that exhausts the miss budget, in which case it signals lock loss.
  always_comb begin
    emit = 1'b0;
    lost = 1'b0;
    if ((state == LOCKED) && at_boundary) begin
      if (!is_sync && miss_limit) begin
        lost = 1'b1;
      end else begin
        emit = 1'b1;
      end
    end
  end

  // Registered outputs; word holds its last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word         <= '0;
      word_valid   <= 1'b0;
      word_is_sync <= 1'b0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      word_valid   <= emit;
      word_is_sync <= emit & is_sync;
      locked       <= (state_next == LOCKED);
      lock_lost    <= lost;
      if (emit) begin
        word <= sr_next;
      end
    end
  end

`ifdef DES_ALIGN_ERRCNT_EN
  // Lock-loss counter, saturating at 255, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (lost && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_des_align.sv
// tb_des_align: randomized self-checking bench for des_align. A driver feeds
// serial bits and steps a bit-history reference model that pushes expected
// words into a scoreboard queue; a monitor pops and compares whenever the
// DUT strobes word_valid, and checks the lock status outputs every cycle.
module tb_des_align;

  localparam logic [15:0] PAT     = 16'h817E;
  localparam int          LOCK_N  = 4;
  localparam int          TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        datain;
  logic [15:0] word;
  logic        word_valid;
  logic        word_is_sync;
  logic        locked;
  logic        lock_lost;
  logic [7:0]  err_cnt;

  des_align #(
    .SYNC_PATTERN(PAT),
    .SYNC_LOCK   (LOCK_N),
    .SYNC_TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .datain      (datain),
    .word        (word),
    .word_valid  (word_valid),
    .word_is_sync(word_is_sync),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic        s;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];

  int   compared = 0;
  int   failed   = 0;
  bit   started  = 0;
  bit   done     = 0;

  // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
  // Boundaries are bit indices congruent to the anchor modulo 16.
  int   mode;
  int   nbit;
  int   anchor;
  int   nsync;
  int   nmiss;
  int   exp_err;
  logic exp_valid;
  logic exp_lost;
  logic exp_locked;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      if (failed <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back(1'b0);
    sb.delete();
    mode       = 0;
    nbit       = 0;
    anchor     = 0;
    nsync      = 0;
    nmiss      = 0;
    exp_err    = 0;
    exp_valid  = 1'b0;
    exp_lost   = 1'b0;
    exp_locked = 1'b0;
  endfunction

  function automatic void modelStep(input bit b);
    logic [15:0] w;
    bit          s;
    bit          bnd;
    hist.push_back(b);
    void'(hist.pop_front());
    w = '0;
    for (int i = 0; i < 16; i++) w = {w[14:0], hist[i]};
    s   = (w == PAT);
    bnd = (((nbit - anchor) % 16) == 0);
    exp_valid = 1'b0;
    exp_lost  = 1'b0;
    if (mode == 0) begin
      if (s) begin
        anchor = nbit;
        nsync  = 1;
        nmiss  = 0;
        mode   = (LOCK_N == 1) ? 2 : 1;
      end
    end else if (mode == 1) begin
      if (bnd) begin
        if (s) begin
          nsync++;
          if (nsync == LOCK_N) begin
            mode  = 2;
            nmiss = 0;
          end
        end else begin
          mode  = 0;
          nsync = 0;
        end
      end
    end else begin
      if (bnd) begin
        if (!s && (nmiss + 1 == TIMEOUT)) begin
          mode     = 0;
          nmiss    = 0;
          nsync    = 0;
          exp_lost = 1'b1;
`ifdef DES_ALIGN_ERRCNT_EN
          if (exp_err < 255) exp_err++;
`endif
        end else begin
          nmiss     = s ? 0 : nmiss + 1;
          exp_valid = 1'b1;
          sb.push_back('{w: w, s: s});
        end
      end
    end
    exp_locked = (mode == 2);
    nbit++;
  endfunction

  // Called at a falling edge: drive one bit, step the model, and return at
  // the next falling edge after the DUT has consumed the bit.
  task automatic applyStimulus(input bit b);
    datain = b;
    modelStep(b);
    @(negedge clk);
  endtask

  task automatic sendWord(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) applyStimulus(w[i]);
  endtask

  task automatic sendRandomBits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'($urandom_range(0, 1)));
  endtask

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_word", 32'(word), 32'h0);
    checkOutput("rst_word_valid", 32'(word_valid), 32'h0);
    checkOutput("rst_word_is_sync", 32'(word_is_sync), 32'h0);
    checkOutput("rst_locked", 32'(locked), 32'h0);
    checkOutput("rst_lock_lost", 32'(lock_lost), 32'h0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
    started = 1'b1;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the model one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started && !done) begin
        checkOutput("word_valid", 32'(word_valid), 32'(exp_valid));
        checkOutput("locked", 32'(locked), 32'(exp_locked));
        checkOutput("lock_lost", 32'(lock_lost), 32'(exp_lost));
        checkOutput("err_cnt", 32'(err_cnt), 32'(exp_err));
        if (word_valid === 1'b1) begin
          if (sb.size() == 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL sb_unexpected: word_valid=1 word=%0h, expected no word queued", word);
          end else begin
            e = sb.pop_front();
            checkOutput("word", 32'(word), 32'(e.w));
            checkOutput("word_is_sync", 32'(word_is_sync), 32'(e.s));
          end
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b1;
    datain = 1'b0;
    #1;
    doReset(3);

    // Acquisition with random leading bits, then a few more syncs.
    sendRandomBits(5);
    repeat (6) sendWord(PAT);
    checkOutput("acq_locked", 32'(locked), 32'h1);

    // Data pass-through.
    sendWord(16'hA5C3);
    sendWord(16'h1234);
    repeat (2) sendWord(PAT);

    // Timeout: 64 zero words drop lock.
    repeat (TIMEOUT) sendWord(16'h0000);
    checkOutput("timeout_locked", 32'(locked), 32'h0);
`ifdef DES_ALIGN_ERRCNT_EN
    checkOutput("timeout_err_cnt", 32'(err_cnt), 32'h1);
`else
    checkOutput("timeout_err_cnt", 32'(err_cnt), 32'h0);
`endif

    // Re-lock, then 63 zeros followed by a sync keep lock.
    repeat (5) sendWord(PAT);
    checkOutput("relock_locked", 32'(locked), 32'h1);
    repeat (TIMEOUT - 1) sendWord(16'h0000);
    sendWord(PAT);
    checkOutput("keep_lock", 32'(locked), 32'h1);
    sendWord(PAT);

    // Phase slip: one extra bit, garbled words until timeout, then re-lock.
    applyStimulus(1'($urandom_range(0, 1)));
    repeat (76) sendWord(PAT);
    checkOutput("slip_relocked", 32'(locked), 32'h1);
`ifdef DES_ALIGN_ERRCNT_EN
    checkOutput("slip_err_cnt", 32'(err_cnt), 32'h2);
`endif

    // Reset in the middle of a locked word.
    sendWord(16'hBEEF);
    for (int i = 15; i >= 9; i--) applyStimulus(1'(i % 2));
    #2;
    doReset(3);

    // False lock: a single sync followed by a non-sync word.
    sendRandomBits(30);
    sendWord(PAT);
    sendWord(16'h0F0F);
    sendRandomBits(40);
    checkOutput("false_lock", 32'(locked), 32'h0);

    // Normal re-acquisition after reset.
    repeat (6) sendWord(PAT);
    checkOutput("post_rst_locked", 32'(locked), 32'h1);

    // Random soak while locked.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) sendWord(PAT);
      else sendWord(16'($urandom));
    end
    checkOutput("soak_locked", 32'(locked), 32'(exp_locked));

    done = 1'b1;
    checkOutput("sb_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
